// File: rtl/projectile_slot_arbiter_if.sv
// Request/grant bundle between the fire requesters, the projectile engines
// and the slot arbiter. The arbiter connects through the slave modport.
interface projectile_slot_arbiter_if #(
    parameter int N_ALIEN = 8,
    parameter int N_SLOTS = 4
);
    localparam int SLOT_W = $clog2(N_SLOTS);

    logic                 player_req;
    logic [N_ALIEN-1:0]   alien_req;
    logic [N_SLOTS-1:0]   slot_release;
    logic                 player_grant;
    logic [N_ALIEN-1:0]   alien_grant;
    logic [SLOT_W-1:0]    alien_slot;
    logic [N_SLOTS-1:0]   slot_busy;

    modport master (
        output player_req, alien_req, slot_release,
        input  player_grant, alien_grant, alien_slot, slot_busy
    );

    modport slave (
        input  player_req, alien_req, slot_release,
        output player_grant, alien_grant, alien_slot, slot_busy
    );
endinterface

// File: rtl/projectile_slot_arbiter.sv
// Shares the projectile slot pool between the player cannon (slot 0) and the
// alien columns (slots 1..N_SLOTS-1). Requests are evaluated once per video
// frame; occupancy is held until the projectile engine releases the slot.
module projectile_slot_arbiter #(
    parameter int N_ALIEN         = 8,
    parameter int N_SLOTS         = 4,
    parameter int PLAYER_COOLDOWN = 4,
    parameter int ALIEN_COOLDOWN  = 16
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    input  logic level_reset,
    input  logic enable,
    projectile_slot_arbiter_if.slave bus
);
    localparam int SLOT_W = $clog2(N_SLOTS);
    localparam int RR_W   = $clog2(N_ALIEN);
    localparam int P_W    = (PLAYER_COOLDOWN > 0) ? $clog2(PLAYER_COOLDOWN + 1) : 1;
    localparam int A_W    = (ALIEN_COOLDOWN > 0) ? $clog2(ALIEN_COOLDOWN + 1) : 1;
    localparam logic [P_W-1:0]  P_LOAD  = P_W'(PLAYER_COOLDOWN);
    localparam logic [A_W-1:0]  A_LOAD  = A_W'(ALIEN_COOLDOWN);
    localparam logic [RR_W-1:0] RR_LAST = RR_W'(N_ALIEN - 1);

    logic                sync1, sync2, sync3;
    logic                tick_en;
    logic [N_SLOTS-1:0]  busy_q, busy_d;
    logic [P_W-1:0]      p_cnt, p_cnt_d;
    logic [A_W-1:0]      a_cnt, a_cnt_d;
    logic [RR_W-1:0]     rr_ptr, rr_d;
    logic                pg_q, pg_d;
    logic [N_ALIEN-1:0]  ag_q, ag_d;
    logic [SLOT_W-1:0]   as_q, as_d;
    logic                free_found;
    logic [SLOT_W-1:0]   free_slot;
    logic                win_found;
    logic [RR_W-1:0]     win_idx;

    assign tick_en          = sync2 & ~sync3 & enable;
    assign bus.player_grant = pg_q;
    assign bus.alien_grant  = ag_q;
    assign bus.alien_slot   = as_q;
    assign bus.slot_busy    = busy_q;

    // Lowest free alien slot, from the registered (pre-release) occupancy.
    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int s = N_SLOTS - 1; s >= 1; s--) begin
            if (!busy_q[s]) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(s);
            end
        end
    end

    // Round-robin winner: first requesting column at or after rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_ALIEN - 1; k >= 0; k--) begin
            if (bus.alien_req[(int'(rr_ptr) + k) % N_ALIEN]) begin
                win_found = 1'b1;
                win_idx   = RR_W'((int'(rr_ptr) + k) % N_ALIEN);
            end
        end
    end

    // Per-tick decision: cooldown decrement, grants, occupancy and pointer update.
    always_comb begin
        busy_d  = busy_q & ~bus.slot_release;
        p_cnt_d = p_cnt;
        a_cnt_d = a_cnt;
        rr_d    = rr_ptr;
        pg_d    = 1'b0;
        ag_d    = '0;
        as_d    = '0;
        if (tick_en) begin
            if (p_cnt != '0) p_cnt_d = p_cnt - 1'b1;
            if (a_cnt != '0) a_cnt_d = a_cnt - 1'b1;
            if (bus.player_req && !busy_q[0] && p_cnt == '0) begin
                pg_d      = 1'b1;
                busy_d[0] = 1'b1;
                p_cnt_d   = P_LOAD;
            end
            if (win_found && free_found && a_cnt == '0) begin
                ag_d              = N_ALIEN'(1) << win_idx;
                as_d              = free_slot;
                busy_d[free_slot] = 1'b1;
                a_cnt_d           = A_LOAD;
                rr_d              = (win_idx == RR_LAST) ? '0 : win_idx + 1'b1;
            end
        end
    end

    // Frame sync chain, occupancy, counters and one-cycle grant pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            busy_q <= '0;
            p_cnt  <= '0;
            a_cnt  <= '0;
            rr_ptr <= '0;
            pg_q   <= 1'b0;
            ag_q   <= '0;
            as_q   <= '0;
        end else if (level_reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            busy_q <= '0;
            p_cnt  <= '0;
            a_cnt  <= '0;
            rr_ptr <= '0;
            pg_q   <= 1'b0;
            ag_q   <= '0;
            as_q   <= '0;
        end else begin
            sync1  <= frame_clk;
            sync2  <= sync1;
            sync3  <= sync2;
            busy_q <= busy_d;
            p_cnt  <= p_cnt_d;
            a_cnt  <= a_cnt_d;
            rr_ptr <= rr_d;
            pg_q   <= pg_d;
            ag_q   <= ag_d;
            as_q   <= as_d;
        end
    end
endmodule

// File: tb/tb_projectile_slot_arbiter.sv
// Randomized bench for projectile_slot_arbiter with a frame-level reference
// model and a few hand-computed expectations after reset.
module tb_projectile_slot_arbiter;
    localparam int NA = 8;
    localparam int NS = 4;
    localparam int PC = 4;
    localparam int AC = 2;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic frame_clk = 1'b0;
    logic level_reset = 1'b0;
    logic enable = 1'b0;

    int checks = 0;
    int errors = 0;

    projectile_slot_arbiter_if #(.N_ALIEN(NA), .N_SLOTS(NS)) bus ();

    projectile_slot_arbiter #(
        .N_ALIEN(NA), .N_SLOTS(NS),
        .PLAYER_COOLDOWN(PC), .ALIEN_COOLDOWN(AC)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .level_reset(level_reset), .enable(enable), .bus(bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    bit m_busy[NS];
    int m_p = 0, m_a = 0, m_rr = 0;
    bit h1 = 0, h2 = 0, h3 = 0;
    bit e_pg = 0;
    int e_ag = -1;
    int e_slot = 0;

    always @(posedge Clk or negedge Reset_n) begin
        bit pre[NS];
        bit tick, pgr, agr;
        int free, win;
        if (!Reset_n || level_reset) begin
            for (int i = 0; i < NS; i++) m_busy[i] = 0;
            m_p = 0; m_a = 0; m_rr = 0;
            h1 = 0; h2 = 0; h3 = 0;
            e_pg = 0; e_ag = -1; e_slot = 0;
        end else begin
            tick = h2 && !h3;
            for (int i = 0; i < NS; i++) pre[i] = m_busy[i];
            e_pg = 0; e_ag = -1;
            for (int i = 0; i < NS; i++) if (bus.slot_release[i]) m_busy[i] = 0;
            if (tick && enable) begin
                pgr = bus.player_req && !pre[0] && m_p == 0;
                free = -1;
                for (int s = 1; s < NS; s++) if (!pre[s] && free < 0) free = s;
                agr = (bus.alien_req != 0) && m_a == 0 && free >= 0;
                if (m_p > 0) m_p--;
                if (m_a > 0) m_a--;
                if (pgr) begin
                    e_pg = 1; m_busy[0] = 1; m_p = PC;
                end
                if (agr) begin
                    win = -1;
                    for (int k = 0; k < NA; k++)
                        if (win < 0 && bus.alien_req[(m_rr + k) % NA]) win = (m_rr + k) % NA;
                    e_ag = win; e_slot = free; m_busy[free] = 1;
                    m_rr = (win + 1) % NA; m_a = AC;
                end
            end
            h3 = h2; h2 = h1; h1 = frame_clk;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge Clk) begin
        int bm;
        bm = 0;
        for (int i = 0; i < NS; i++) if (m_busy[i]) bm |= (1 << i);
        chk("player_grant", int'(bus.player_grant), int'(e_pg));
        chk("alien_grant", int'(bus.alien_grant), (e_ag >= 0) ? (1 << e_ag) : 0);
        if (e_ag >= 0) chk("alien_slot", int'(bus.alien_slot), e_slot);
        chk("slot_busy", int'(bus.slot_busy), bm);
    end

    initial begin
        int fc_cnt, fc_per;
        bus.player_req = 0;
        bus.alien_req = '0;
        bus.slot_release = '0;
        repeat (3) @(negedge Clk);
        chk("lit_reset_busy", int'(bus.slot_busy), 0);
        chk("lit_reset_pg", int'(bus.player_grant), 0);
        chk("lit_reset_ag", int'(bus.alien_grant), 0);
        #1 Reset_n = 1;

        // First frame after reset: player and alien granted together.
        @(negedge Clk); #1;
        enable = 1; bus.player_req = 1; bus.alien_req = 8'hFF; frame_clk = 1;
        @(negedge Clk);
        chk("lit_lat1_pg", int'(bus.player_grant), 0);
        @(negedge Clk);
        chk("lit_lat2_pg", int'(bus.player_grant), 0);
        @(negedge Clk);
        chk("lit_first_pg", int'(bus.player_grant), 1);
        chk("lit_first_ag", int'(bus.alien_grant), 1);
        chk("lit_first_slot", int'(bus.alien_slot), 1);
        chk("lit_first_busy", int'(bus.slot_busy), 3);
        @(negedge Clk);
        chk("lit_pulse_pg", int'(bus.player_grant), 0);
        chk("lit_pulse_ag", int'(bus.alien_grant), 0);

        // Second frame: slot 0 busy and alien cooldown running, nothing granted.
        #1 frame_clk = 0;
        repeat (4) @(negedge Clk);
        #1 frame_clk = 1;
        repeat (3) @(negedge Clk);
        chk("lit_second_pg", int'(bus.player_grant), 0);
        chk("lit_second_ag", int'(bus.alien_grant), 0);
        chk("lit_second_busy", int'(bus.slot_busy), 3);

        // Randomized phase.
        fc_cnt = 0; fc_per = 5;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge Clk); #1;
            fc_cnt++;
            if (fc_cnt >= fc_per) begin
                frame_clk = ~frame_clk;
                fc_cnt = 0;
                fc_per = $urandom_range(2, 8);
            end
            bus.player_req = ($urandom_range(0, 3) != 0);
            bus.alien_req = ($urandom_range(0, 4) == 0) ? '0 : NA'($urandom);
            for (int i = 0; i < NS; i++) bus.slot_release[i] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            level_reset = ($urandom_range(0, 299) == 0);
            if (cyc == 2000) Reset_n = 0;
            if (cyc == 2003) Reset_n = 1;
        end
        @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
